// File: rtl/ci_stim_pkg.sv
// Shared types and constants for the biphasic stimulation pulse sequencer.
package ci_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_GAP,
    ST_PH2,
    ST_DIS,
    ST_NEXT
  } stim_state_e;

  localparam logic [1:0] MODE_CF = 2'd0;
  localparam logic [1:0] MODE_AF = 2'd1;
  localparam logic [1:0] MODE_MC = 2'd2;
  localparam logic [1:0] MODE_MA = 2'd3;

  localparam int MAX_CH = 32;

  function automatic int ch_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [ch_idx_w(MAX_CH)-1:0] ch_idx_t;

  function automatic logic ph1_is_anodic(input logic [1:0] mode);
    return (mode == MODE_AF) || (mode == MODE_MA);
  endfunction

  function automatic logic is_monophasic(input logic [1:0] mode);
    return (mode == MODE_MC) || (mode == MODE_MA);
  endfunction

endpackage

// File: rtl/ci_stim_ch_pick.sv
// Finds the next set bit in a channel mask, above (or optionally at) a given index.
module ci_stim_ch_pick #(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] i_mask,
  input  logic [CH_W-1:0] i_cur,
  input  logic            i_incl,
  output logic [CH_W-1:0] o_idx,
  output logic            o_found
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && ((i > int'(i_cur)) || (i_incl && (i == int'(i_cur))))) begin
        o_idx   = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ci_stim_pulse_seq.sv
// Multi-channel biphasic stimulation sequencer: scans enabled electrodes and drives
// phase/gap/phase/discharge switch patterns with compliance-error and abort handling.
module ci_stim_pulse_seq
  import ci_stim_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DAC_W = 8,
  parameter int CNT_W = 16,
  parameter int BCG_W = 3,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [N_CH-1:0]  i_ch_mask,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_ph_w,
  input  logic [CNT_W-1:0] i_gap_w,
  input  logic [CNT_W-1:0] i_dis_w,
  input  logic [DAC_W-1:0] i_amp1,
  input  logic [DAC_W-1:0] i_amp2,
  input  logic [BCG_W-1:0] i_bcg1,
  input  logic [BCG_W-1:0] i_bcg2,
  input  logic [N_CH-1:0]  i_comp_err,
  output logic [N_CH-1:0]  o_stim_an,
  output logic [N_CH-1:0]  o_stim_ca,
  output logic [DAC_W-1:0] o_dac0_val,
  output logic [DAC_W-1:0] o_dac1_val,
  output logic [BCG_W-1:0] o_bcg0_sel,
  output logic [BCG_W-1:0] o_bcg1_sel,
  output logic             o_comp_en_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CH_W-1:0]  o_err_ch
);

  stim_state_e      state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;

  logic [N_CH-1:0]  mask_q, mask_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] ph_w_q, ph_w_d, gap_w_q, gap_w_d, dis_w_q, dis_w_d;
  logic [DAC_W-1:0] amp1_q, amp1_d, amp2_q, amp2_d;
  logic [BCG_W-1:0] bcg_ph1_q, bcg_ph1_d, bcg_ph2_q, bcg_ph2_d;

  logic [N_CH-1:0]  an_q, an_d, ca_q, ca_d;
  logic [DAC_W-1:0] dac0_q, dac0_d, dac1_q, dac1_d;
  logic [BCG_W-1:0] bcg0_sel_q, bcg0_sel_d, bcg1_sel_q, bcg1_sel_d;
  logic             comp_en_n_q, comp_en_n_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CH_W-1:0]  err_ch_q, err_ch_d;

  logic             start_acc, err_hit;
  logic [CNT_W-1:0] ph_ld, gap_ld, dis_ld;
  logic [N_CH-1:0]  pick_mask;
  logic [CH_W-1:0]  pick_cur, pick_idx;
  logic             pick_found;

  assign start_acc = (state_q == ST_IDLE) && i_start;

  // Configuration is only captured on an accepted start; otherwise it holds.
  always_comb begin
    mask_d    = start_acc ? i_ch_mask : mask_q;
    mode_d    = start_acc ? i_mode    : mode_q;
    ph_w_d    = start_acc ? i_ph_w    : ph_w_q;
    gap_w_d   = start_acc ? i_gap_w   : gap_w_q;
    dis_w_d   = start_acc ? i_dis_w   : dis_w_q;
    amp1_d    = start_acc ? i_amp1    : amp1_q;
    amp2_d    = start_acc ? i_amp2    : amp2_q;
    bcg_ph1_d = start_acc ? i_bcg1    : bcg_ph1_q;
    bcg_ph2_d = start_acc ? i_bcg2    : bcg_ph2_q;
  end

  assign ph_ld  = (ph_w_d  == '0) ? '0 : ph_w_d  - CNT_W'(1);
  assign dis_ld = (dis_w_d == '0) ? '0 : dis_w_d - CNT_W'(1);
  assign gap_ld = gap_w_d - CNT_W'(1);

  assign err_hit = ((state_q == ST_PH1) || (state_q == ST_PH2)) && i_comp_err[ch_q];

  assign pick_mask = (state_q == ST_IDLE) ? i_ch_mask : mask_q;
  assign pick_cur  = (state_q == ST_IDLE) ? '0 : ch_q;

  ci_stim_ch_pick #(
    .N_CH(N_CH),
    .CH_W(CH_W)
  ) u_pick (
    .i_mask (pick_mask),
    .i_cur  (pick_cur),
    .i_incl (state_q == ST_IDLE),
    .o_idx  (pick_idx),
    .o_found(pick_found)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    err_d    = err_q;
    err_ch_d = err_ch_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d    = 1'b0;
          err_ch_d = '0;
          stop_d   = 1'b0;
          if (pick_found) begin
            state_d = ST_PH1;
            ch_d    = pick_idx;
            cnt_d   = ph_ld;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PH1, ST_PH2: begin
        if (err_hit || i_abort) begin
          state_d = ST_DIS;
          cnt_d   = dis_ld;
          stop_d  = 1'b1;
          if (err_hit) begin
            err_d    = 1'b1;
            err_ch_d = ch_q;
          end
        end else if (cnt_q == '0) begin
          if ((state_q == ST_PH2) || is_monophasic(mode_q)) begin
            state_d = ST_DIS;
            cnt_d   = dis_ld;
          end else if (gap_w_q != '0) begin
            state_d = ST_GAP;
            cnt_d   = gap_ld;
          end else begin
            state_d = ST_PH2;
            cnt_d   = ph_ld;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (i_abort) begin
          state_d = ST_DIS;
          cnt_d   = dis_ld;
          stop_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_PH2;
          cnt_d   = ph_ld;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIS: begin
        if (cnt_q == '0) begin
          if (stop_q || i_abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (i_abort) stop_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (!stop_q && !i_abort && pick_found) begin
          state_d = ST_PH1;
          ch_d    = pick_idx;
          cnt_d   = ph_ld;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    an_d        = '0;
    ca_d        = '0;
    dac0_d      = '0;
    dac1_d      = '0;
    bcg0_sel_d  = '0;
    bcg1_sel_d  = '0;
    comp_en_n_d = 1'b1;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_PH1: begin
        if (ph1_is_anodic(mode_d)) an_d[ch_d] = 1'b1;
        else                       ca_d[ch_d] = 1'b1;
        dac0_d      = amp1_d;
        bcg0_sel_d  = bcg_ph1_d;
        comp_en_n_d = 1'b0;
      end
      ST_PH2: begin
        if (ph1_is_anodic(mode_d)) ca_d[ch_d] = 1'b1;
        else                       an_d[ch_d] = 1'b1;
        dac1_d      = amp2_d;
        bcg1_sel_d  = bcg_ph2_d;
        comp_en_n_d = 1'b0;
      end
      ST_DIS: begin
        an_d[ch_d] = 1'b1;
        ca_d[ch_d] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      stop_q      <= 1'b0;
      mask_q      <= '0;
      mode_q      <= '0;
      ph_w_q      <= '0;
      gap_w_q     <= '0;
      dis_w_q     <= '0;
      amp1_q      <= '0;
      amp2_q      <= '0;
      bcg_ph1_q   <= '0;
      bcg_ph2_q   <= '0;
      an_q        <= '0;
      ca_q        <= '0;
      dac0_q      <= '0;
      dac1_q      <= '0;
      bcg0_sel_q  <= '0;
      bcg1_sel_q  <= '0;
      comp_en_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      ph_w_q      <= ph_w_d;
      gap_w_q     <= gap_w_d;
      dis_w_q     <= dis_w_d;
      amp1_q      <= amp1_d;
      amp2_q      <= amp2_d;
      bcg_ph1_q   <= bcg_ph1_d;
      bcg_ph2_q   <= bcg_ph2_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
      dac0_q      <= dac0_d;
      dac1_q      <= dac1_d;
      bcg0_sel_q  <= bcg0_sel_d;
      bcg1_sel_q  <= bcg1_sel_d;
      comp_en_n_q <= comp_en_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_ch_q    <= err_ch_d;
    end
  end

  assign o_stim_an   = an_q;
  assign o_stim_ca   = ca_q;
  assign o_dac0_val  = dac0_q;
  assign o_dac1_val  = dac1_q;
  assign o_bcg0_sel  = bcg0_sel_q;
  assign o_bcg1_sel  = bcg1_sel_q;
  assign o_comp_en_n = comp_en_n_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_ch    = err_ch_q;

endmodule

// File: tb/tb_ci_stim_pulse_seq.sv
// Directed bench for ci_stim_pulse_seq with cycle-by-cycle expected output snapshots.
module tb_ci_stim_pulse_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start, i_abort;
  logic [7:0]  i_ch_mask, i_comp_err;
  logic [1:0]  i_mode;
  logic [15:0] i_ph_w, i_gap_w, i_dis_w;
  logic [7:0]  i_amp1, i_amp2;
  logic [2:0]  i_bcg1, i_bcg2;
  logic [7:0]  o_stim_an, o_stim_ca, o_dac0_val, o_dac1_val;
  logic [2:0]  o_bcg0_sel, o_bcg1_sel, o_err_ch;
  logic        o_comp_en_n, o_busy, o_done, o_err;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;

  always #5 i_clk = ~i_clk;

  ci_stim_pulse_seq dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_ch_mask  (i_ch_mask),
    .i_mode     (i_mode),
    .i_ph_w     (i_ph_w),
    .i_gap_w    (i_gap_w),
    .i_dis_w    (i_dis_w),
    .i_amp1     (i_amp1),
    .i_amp2     (i_amp2),
    .i_bcg1     (i_bcg1),
    .i_bcg2     (i_bcg2),
    .i_comp_err (i_comp_err),
    .o_stim_an  (o_stim_an),
    .o_stim_ca  (o_stim_ca),
    .o_dac0_val (o_dac0_val),
    .o_dac1_val (o_dac1_val),
    .o_bcg0_sel (o_bcg0_sel),
    .o_bcg1_sel (o_bcg1_sel),
    .o_comp_en_n(o_comp_en_n),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_err_ch   (o_err_ch)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] a, c, d0, d1,
                                       input logic [2:0] b0, b1,
                                       input logic cen, bz, dn, er,
                                       input logic [2:0] ec);
    return {19'd0, a, c, d0, d1, b0, b1, cen, bz, dn, er, ec};
  endfunction

  function automatic logic [63:0] snap();
    return pack(o_stim_an, o_stim_ca, o_dac0_val, o_dac1_val, o_bcg0_sel, o_bcg1_sel,
                o_comp_en_n, o_busy, o_done, o_err, o_err_ch);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic [7:0] e_an, e_ca, e_d0, e_d1,
                         input logic [2:0] e_b0, e_b1,
                         input logic e_cen, e_busy, e_done, e_err,
                         input logic [2:0] e_ech);
    chk(tag, snap(), pack(e_an, e_ca, e_d0, e_d1, e_b0, e_b1, e_cen, e_busy, e_done, e_err, e_ech));
    if (o_busy) busy_cnt++;
    tick();
  endtask

  task automatic start_seq();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_comp_err = 8'h00;
    i_ch_mask = 8'h00; i_mode = 2'd0;
    i_ph_w = 16'd0; i_gap_w = 16'd0; i_dis_w = 16'd0;
    i_amp1 = 8'h00; i_amp2 = 8'h00; i_bcg1 = 3'd0; i_bcg2 = 3'd0;
    tick(); tick();
    chk("reset_state", snap(), pack(8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0));
    i_rst = 1'b0;
    tick();

    // Mode 0 on ch0 and ch2; a second start and config change mid-run must be ignored.
    i_ch_mask = 8'h05; i_mode = 2'd0; i_ph_w = 16'd3; i_gap_w = 16'd2; i_dis_w = 16'd4;
    i_amp1 = 8'h40; i_amp2 = 8'h20; i_bcg1 = 3'd3; i_bcg2 = 3'd5;
    busy_cnt = 0;
    start_seq();
    for (int k = 0; k < 2; k++) begin
      m = (k == 0) ? 8'h01 : 8'h04;
      for (int j = 0; j < 3; j++) exp_cyc("t1_ph1", 8'h00, m, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
      if (k == 0) begin
        i_start = 1'b1; i_ch_mask = 8'hFF; i_amp1 = 8'h7F;
      end
      exp_cyc("t1_gap", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
      i_start = 1'b0;
      exp_cyc("t1_gap", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
      for (int j = 0; j < 3; j++) exp_cyc("t1_ph2", m, 8'h00, 8'h00, 8'h20, 3'd0, 3'd5, 0, 1, 0, 0, 3'd0);
      for (int j = 0; j < 4; j++) exp_cyc("t1_dis", m, m, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
      exp_cyc("t1_next", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    end
    exp_cyc("t1_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 0, 3'd0);
    exp_cyc("t1_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd26);

    // Mode 1, no gap, discharge width 0 treated as 1.
    i_ch_mask = 8'h01; i_mode = 2'd1; i_ph_w = 16'd1; i_gap_w = 16'd0; i_dis_w = 16'd0;
    i_amp1 = 8'h11; i_amp2 = 8'h22; i_bcg1 = 3'd1; i_bcg2 = 3'd2;
    start_seq();
    exp_cyc("t2_ph1", 8'h01, 8'h00, 8'h11, 8'h00, 3'd1, 3'd0, 0, 1, 0, 0, 3'd0);
    exp_cyc("t2_ph2", 8'h00, 8'h01, 8'h00, 8'h22, 3'd0, 3'd2, 0, 1, 0, 0, 3'd0);
    exp_cyc("t2_dis", 8'h01, 8'h01, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t2_next", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t2_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 0, 3'd0);

    // Mode 3 monophasic anodic, phase width 0 treated as 1.
    i_mode = 2'd3; i_ph_w = 16'd0; i_dis_w = 16'd2;
    start_seq();
    exp_cyc("t3_ph1", 8'h01, 8'h00, 8'h11, 8'h00, 3'd1, 3'd0, 0, 1, 0, 0, 3'd0);
    exp_cyc("t3_dis", 8'h01, 8'h01, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t3_dis", 8'h01, 8'h01, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t3_next", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t3_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 0, 3'd0);

    // Compliance error on ch2 during its PH1; ch3 must never run.
    i_ch_mask = 8'h0C; i_mode = 2'd0; i_ph_w = 16'd3; i_gap_w = 16'd1; i_dis_w = 16'd2;
    i_amp1 = 8'h40; i_amp2 = 8'h20; i_bcg1 = 3'd3; i_bcg2 = 3'd5;
    start_seq();
    exp_cyc("t4_ph1", 8'h00, 8'h04, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
    i_comp_err = 8'h04;
    exp_cyc("t4_ph1", 8'h00, 8'h04, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
    i_comp_err = 8'h00;
    exp_cyc("t4_dis", 8'h04, 8'h04, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 1, 3'd2);
    exp_cyc("t4_dis", 8'h04, 8'h04, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 1, 3'd2);
    exp_cyc("t4_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 1, 3'd2);
    exp_cyc("t4_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 1, 3'd2);
    exp_cyc("t4_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 1, 3'd2);

    // Error on inactive ch5 ignored; abort during GAP.
    i_ch_mask = 8'h02; i_ph_w = 16'd2; i_gap_w = 16'd3; i_dis_w = 16'd1;
    i_comp_err = 8'h20;
    start_seq();
    exp_cyc("t5_ph1", 8'h00, 8'h02, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
    exp_cyc("t5_ph1", 8'h00, 8'h02, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
    i_comp_err = 8'h00;
    i_abort = 1'b1;
    exp_cyc("t5_gap", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    i_abort = 1'b0;
    exp_cyc("t5_dis", 8'h02, 8'h02, 8'h00, 8'h00, 3'd0, 3'd0, 1, 1, 0, 0, 3'd0);
    exp_cyc("t5_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 0, 3'd0);

    // Empty mask: done next cycle, no activity; abort in IDLE ignored.
    i_ch_mask = 8'h00;
    start_seq();
    exp_cyc("t6_done", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 1, 0, 3'd0);
    i_abort = 1'b1;
    exp_cyc("t6_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0);
    i_abort = 1'b0;
    exp_cyc("t6_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0);

    // Reset asserted mid-PH2 clears outputs without a clock edge.
    i_ch_mask = 8'h01; i_mode = 2'd0; i_ph_w = 16'd4; i_gap_w = 16'd0; i_dis_w = 16'd1;
    start_seq();
    for (int j = 0; j < 4; j++) exp_cyc("t7_ph1", 8'h00, 8'h01, 8'h40, 8'h00, 3'd3, 3'd0, 0, 1, 0, 0, 3'd0);
    chk("t7_ph2", snap(), pack(8'h01, 8'h00, 8'h00, 8'h20, 3'd0, 3'd5, 0, 1, 0, 0, 3'd0));
    #2;
    i_rst = 1'b1;
    #1;
    chk("t7_async_rst", snap(), pack(8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0));
    tick(); tick();
    #2;
    i_rst = 1'b0;
    tick();
    exp_cyc("t7_idle", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1, 0, 0, 0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
